// File: rtl/bin_to_bcd4_seq.sv
// bin_to_bcd4_seq: sequential double-dabble converter from binary to four held BCD digits
module bin_to_bcd4_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       dig0,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3
);
  localparam int SW = BIN_W + 16;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [SW-1:0] sr, adj, sh;
  logic [CW-1:0] cnt;
  logic ovf_pending;
  logic last;
  assign last = (cnt == CW'(1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: one iteration per cycle in SHIFT, a single DONE cycle, then back to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SHIFT : IDLE;
      SHIFT:   state_nx = last ? DONE : SHIFT;
      default: state_nx = IDLE;
    endcase
  end
  // add-3 to every BCD field holding 5 or more, then shift left by one
  always_comb begin
    adj = sr;
    for (int k = 0; k < 4; k++)
      if (sr[BIN_W+4*k +: 4] >= 4'd5) adj[BIN_W+4*k +: 4] = sr[BIN_W+4*k +: 4] + 4'd3;
    sh = {adj[SW-2:0], 1'b0};
  end
  // datapath: load on accept, iterate in SHIFT, update held outputs on the final iteration
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      ovf_pending <= 1'b0;
      ovf <= 1'b0;
      {dig3, dig2, dig1, dig0} <= 16'h0;
    end else if (state == IDLE && start) begin
      sr <= {16'b0, bin};
      cnt <= CW'(BIN_W);
      ovf_pending <= (32'(bin) > 32'd9999);
    end else if (state == SHIFT) begin
      sr <= sh;
      cnt <= cnt - CW'(1);
      if (last) begin
        {dig3, dig2, dig1, dig0} <= ovf_pending ? 16'hEEEE : sh[BIN_W +: 16];
        ovf <= ovf_pending;
      end
    end
endmodule

// File: tb/tb_bin_to_bcd4_seq.sv
// tb_bin_to_bcd4_seq: table, directed and random checks of the BCD converter against an arithmetic model
module tb_bin_to_bcd4_seq;
  logic clk = 0, rst_n = 0, start = 0;
  logic [13:0] bin = '0;
  logic busy, done, ovf;
  logic [3:0] dig0, dig1, dig2, dig3;
  int errors = 0, checks = 0;

  bin_to_bcd4_seq #(.BIN_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .busy(busy), .done(done),
    .ovf(ovf), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3)
  );

  always #5 clk = ~clk;

  typedef struct {logic [13:0] b; logic [16:0] e;} vec_t;
  vec_t tbl[9];

  function automatic logic [16:0] model(int v);
    if (v > 9999) return {1'b1, 16'hEEEE};
    return {1'b0, 4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [16:0] outs();
    return {ovf, dig3, dig2, dig1, dig0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic convert(input logic [13:0] v, input logic [16:0] exp);
    int n;
    logic [16:0] prev;
    logic held;
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    prev = outs();
    held = 1;
    @(negedge clk);
    start = 1;
    bin = v;
    @(posedge clk);
    #1;
    start = 0;
    bin = 14'($urandom);
    chk("busy_after_accept", busy, 1);
    n = 1;
    while (!done && n < 40) begin
      if (outs() != prev) held = 0;
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", n, 15);
    chk("hold_between", held, 1);
    chk($sformatf("result_%0d", v), outs(), exp);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("busy_low_after", busy, 0);
  endtask

  initial begin
    int n, dn;
    logic [13:0] r;
    tbl[0] = '{14'd1234, {1'b0, 16'h1234}};
    tbl[1] = '{14'd0, {1'b0, 16'h0000}};
    tbl[2] = '{14'd9999, {1'b0, 16'h9999}};
    tbl[3] = '{14'd10, {1'b0, 16'h0010}};
    tbl[4] = '{14'd10000, {1'b1, 16'hEEEE}};
    tbl[5] = '{14'd16383, {1'b1, 16'hEEEE}};
    tbl[6] = '{14'd42, {1'b0, 16'h0042}};
    tbl[7] = '{14'd300, {1'b0, 16'h0300}};
    tbl[8] = '{14'd8191, {1'b0, 16'h8191}};
    #12;
    chk("reset_outs", outs(), 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 9; i++) convert(tbl[i].b, tbl[i].e);

    // requests while busy are dropped
    @(negedge clk);
    start = 1;
    bin = 14'd1234;
    @(negedge clk);
    start = 0;
    repeat (1) @(negedge clk);
    start = 1;
    bin = 14'd5678;
    repeat (6) @(negedge clk);
    start = 0;
    n = 0;
    dn = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        dn++;
        chk("ignored_start_result", outs(), {1'b0, 16'h1234});
      end
    end
    chk("ignored_start_dones", dn, 1);

    // asynchronous reset mid-conversion
    convert(14'd4321, {1'b0, 16'h4321});
    @(negedge clk);
    start = 1;
    bin = 14'd9876;
    @(posedge clk);
    #1;
    start = 0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("abort_outs", outs(), 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    dn = 0;
    repeat (3) begin @(posedge clk); #1; if (done) dn++; end
    @(negedge clk);
    rst_n = 1;
    repeat (20) begin @(posedge clk); #1; if (done) dn++; end
    chk("abort_no_done", dn, 0);
    chk("abort_outs_held", outs(), 0);
    convert(14'd5555, {1'b0, 16'h5555});

    // start held high: periodic conversions
    @(negedge clk);
    start = 1;
    bin = 14'd300;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("held_first_done", done, 1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!done && n < 40);
      chk("held_period", n, 16);
      chk("held_result", outs(), {1'b0, 16'h0300});
    end
    start = 0;
    repeat (20) @(posedge clk);
    #1;

    // random values against the arithmetic model
    for (int k = 0; k < 40; k++) begin
      r = 14'($urandom_range(0, 16383));
      if (k % 4 == 0) r = 14'($urandom_range(9990, 10010));
      convert(r, model(int'(r)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd4_seq.md
Name: bin_to_bcd4_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) converter from an unsigned binary value to four BCD digits.
- Sits directly upstream of the 4-digit seven-segment driver. dig0..dig3 connect straight to its in0..in3 inputs; dig0 is the ones digit and drives the rightmost display.
- Digit outputs are registered and held between conversions, so the display never shows intermediate shift values.

Parameters:
- BIN_W, 14, width of the binary input. Legal range is 4..14. 14 is the smallest width that covers 0..9999.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  BIN_W  unsigned value to convert; sampled on the edge that accepts start.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  one-cycle pulse; the new digit values are valid in the same cycle.
- ovf  output  1  high when the last accepted value exceeded 9999; held until the next completion.
- dig0  output  4  BCD ones digit; goes to driver in0.
- dig1  output  4  BCD tens digit; goes to driver in1.
- dig2  output  4  BCD hundreds digit; goes to driver in2.
- dig3  output  4  BCD thousands digit; goes to driver in3.

Behaviour:
- Reset (rst_n low, acts asynchronously):
  - state = IDLE.
  - dig0..dig3 = 0, done = 0, ovf = 0, busy = 0.
  - Internal shift register and counter cleared.
- Reset mid-conversion aborts the conversion. No done pulse is produced, and outputs read 0 until the next completed conversion.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - On start = 1 at an edge: load the shift register with {16'b0, bin}, load the iteration counter with BIN_W, and capture ovf_pending = (bin > 9999). Go to SHIFT.
  - On start = 0: stay in IDLE.
- SHIFT, one iteration per clock:
  - First, add 3 to each 4-bit BCD field whose value is ≥ 5 (combinational). Then shift the whole register left by 1 and decrement the counter.
  - The edge that performs the final iteration (counter 1 → 0) moves the FSM to DONE. On that same edge the output registers load as follows:
    - If ovf_pending = 0: dig3..dig0 take the four BCD fields, and ovf = 0.
    - If ovf_pending = 1: dig3..dig0 = 4'hE each (the driver shows "EEEE"), and ovf = 1.
- DONE: done = 1 for exactly this one cycle. The next edge returns to IDLE unconditionally.
- Latency:
  - done is high in the cycle after the (BIN_W+1)-th rising edge, counting the start-accepting edge as edge 1.
  - For BIN_W = 14, done rises 15 edges after start is accepted.
  - The iteration count is fixed and independent of the value.
- busy = 1 in SHIFT and DONE, 0 in IDLE. Minimum spacing between accepted starts is BIN_W+2 cycles.
- start is ignored in SHIFT and DONE. It is not queued, and a start still held high is accepted again once back in IDLE (level-sensitive in IDLE).
- bin may change freely after the accepting edge; only the captured value is converted.
- Outputs dig*/ovf change only on the completion edge or on reset. Between conversions they hold.
- BCD field adjustment never produces a field > 9 after shifting.
- The top 2 bits of the 16-bit BCD field may be discarded only in the overflow case; in that case the outputs are forced to E regardless.
- For BIN_W ≤ 13 the maximum input is ≤ 8191, so ovf can never assert.

Test Plan:
- BIN_W = 14, bin = 1234, start pulse 1 cycle → busy high next cycle; done pulses exactly 15 edges after acceptance; dig3..dig0 = 1,2,3,4; ovf = 0; busy low after done.
- bin = 0, then bin = 9999, then bin = 10 (back-to-back, each started the cycle after the previous done) → 0,0,0,0; then 9,9,9,9; then 0,0,1,0; ovf = 0 throughout; outputs hold between done pulses.
- bin = 10000, and separately bin = 16383 → dig3..dig0 = E,E,E,E and ovf = 1. A following conversion of bin = 42 gives 0,0,4,2 with ovf = 0.
- Start 1234, then assert start with bin = 5678 on cycles 3..8 while busy → the second request is ignored; the single done yields 1,2,3,4; no second done unless start is re-asserted in IDLE.
- Complete 4321, then start 9876 and drop rst_n asynchronously (mid-cycle) at iteration 7 → all outputs go to 0 immediately with no done. After release, a start of 5555 completes normally with 5,5,5,5.
- Hold start high continuously with bin = 300 → repeated conversions, one done every 16 cycles, each showing 0,3,0,0.
